// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: 2-flop sync, sampled saturating debounce,
// press pulse and press-toggled level. Define BUTTON_REPEAT_EN for auto-repeat pulses.
module button_conditioner #(
   parameter int WIDTH          = 4,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200,
   parameter int REPEAT_TICKS   = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_in,
   output logic [WIDTH-1:0] o_stable,
   output logic [WIDTH-1:0] o_out,
   output logic [WIDTH-1:0] o_toggle
);
   localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int DW = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [DW-1:0] DB_SAT      = DW'(PULSE_CNT_MAX);

   if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 || REPEAT_TICKS < 1) begin : g_bad_params
      $error("button_conditioner: SAMPLE_CNT_MAX>=2, PULSE_CNT_MAX>=1, REPEAT_TICKS>=1 required");
   end

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_stable_q;
   logic [WIDTH-1:0] r_toggle;
   logic [SW-1:0]    r_sample_cnt;
   logic [DW-1:0]    r_db_cnt [WIDTH];
   logic             w_tick;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_press;
   logic [WIDTH-1:0] w_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_in;
         r_sync <= r_meta;
      end
   end

   assign w_tick = (r_sample_cnt == SAMPLE_LAST);

   always_ff @(posedge clk) begin
      if (rst || w_tick) begin
         r_sample_cnt <= '0;
      end else begin
         r_sample_cnt <= r_sample_cnt + SW'(1);
      end
   end

   // A single low sync cycle wipes qualification progress, regardless of tick.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (rst || !r_sync[i]) begin
            r_db_cnt[i] <= '0;
         end else if (w_tick && (r_db_cnt[i] != DB_SAT)) begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
         end
      end
   end

   always_comb begin
      w_stable = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_stable[i] = (r_db_cnt[i] == DB_SAT);
      end
   end

   assign w_press = w_stable & ~r_stable_q;

`ifdef BUTTON_REPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);

   logic [RW-1:0]    r_rep_cnt [WIDTH];
   logic [WIDTH-1:0] w_repeat;

   always_comb begin
      w_repeat = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_repeat[i] = w_stable[i] && (r_rep_cnt[i] == REP_LAST);
      end
   end

   // On restart a coincident tick is kept so the repeat period never stretches.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (rst || !w_stable[i]) begin
            r_rep_cnt[i] <= '0;
         end else if (r_rep_cnt[i] == REP_LAST) begin
            r_rep_cnt[i] <= w_tick ? RW'(1) : '0;
         end else if (w_tick) begin
            r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
         end
      end
   end

   assign w_pulse = w_press | w_repeat;
`else
   assign w_pulse = w_press;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable_q <= '0;
         r_toggle   <= '0;
      end else begin
         r_stable_q <= w_stable;
         r_toggle   <= r_toggle ^ w_pulse;
      end
   end

   assign o_stable = w_stable;
   assign o_out    = w_pulse;
   assign o_toggle = r_toggle;
endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner: a timing-arithmetic reference model feeds
// an expected-pulse queue; a monitor pops and compares whenever the DUT pulses.
module tb_button_conditioner;
   localparam int W = 4;
   localparam int M = 4;
   localparam int P = 3;
   localparam int R = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] i_in = '1;
   logic [W-1:0] o_stable;
   logic [W-1:0] o_out;
   logic [W-1:0] o_toggle;

   always #4 clk = ~clk;

   button_conditioner #(
      .WIDTH(W), .SAMPLE_CNT_MAX(M), .PULSE_CNT_MAX(P), .REPEAT_TICKS(R)
   ) dut (
      .clk(clk), .rst(rst), .i_in(i_in),
      .o_stable(o_stable), .o_out(o_out), .o_toggle(o_toggle)
   );

   typedef struct {
      int           cyc;
      logic [W-1:0] mask;
   } pulse_t;

   pulse_t       q_exp[$];
   int           ch0_pulses[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           k = -1;
   logic [W-1:0] exp_stable = '0;
   logic [W-1:0] exp_toggle = '0;
   int           dut_pulses[W];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, k);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, k);
      end
   endtask

   // Reference model. Cycle k = values visible after the k-th rising edge.
   // sync(k) = in(k-1) unless reset at k or k-1; ticks fall where (k - last reset) mod M == M-1.
   // A sync-high run starting at cycle a qualifies on its P-th tick, stable from the cycle after.
   initial begin : model
      int           last_rst;
      bit           rst_prev;
      logic [W-1:0] in_prev;
      int           run_start[W];
      int           stab_start[W];
      logic [W-1:0] prev_stable;
      logic [W-1:0] prev_out;
      logic [W-1:0] s_now;
      logic [W-1:0] o_now;
      int           ph;
      int           qual;
      bit           sync_c;
      last_rst = -1;
      rst_prev = 1'b1;
      in_prev = '0;
      prev_stable = '0;
      prev_out = '0;
      for (int c = 0; c < W; c++) begin
         run_start[c] = -1;
         stab_start[c] = 0;
      end
      forever begin
         @(posedge clk);
         k++;
         if (rst) last_rst = k;
         for (int c = 0; c < W; c++) begin
            s_now[c] = 1'b0;
            if (!rst && run_start[c] >= 0) begin
               ph = (run_start[c] - last_rst) % M;
               qual = run_start[c] + (M - 1 - ph) + (P - 1) * M;
               s_now[c] = (qual <= k - 1);
            end
            o_now[c] = s_now[c] && !prev_stable[c];
            if (o_now[c]) stab_start[c] = k;
`ifdef BUTTON_REPEAT_EN
            if (s_now[c] && prev_stable[c] && ((k - stab_start[c]) % (R * M) == 0))
               o_now[c] = 1'b1;
`endif
            sync_c = !rst && !rst_prev && in_prev[c];
            if (!sync_c) run_start[c] = -1;
            else if (run_start[c] < 0) run_start[c] = k;
         end
         exp_toggle = rst ? '0 : (exp_toggle ^ prev_out);
         exp_stable = s_now;
         if (o_now != '0) q_exp.push_back('{k, o_now});
         prev_stable = s_now;
         prev_out = o_now;
         rst_prev = rst;
         in_prev = i_in;
      end
   end

   initial begin : monitor
      pulse_t e;
      forever begin
         @(negedge clk);
         if (k < 0) continue;
         check("stable", int'(o_stable), int'(exp_stable));
         check("toggle", int'(o_toggle), int'(exp_toggle));
         while (q_exp.size() > 0 && q_exp[0].cyc < k) begin
            e = q_exp.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_pulse: got no out at cycle %0d, required mask %b", e.cyc, e.mask);
         end
         if (o_out != '0) begin
            for (int c = 0; c < W; c++) if (o_out[c]) dut_pulses[c]++;
            if (o_out[0]) ch0_pulses.push_back(k);
            if (q_exp.size() > 0 && q_exp[0].cyc == k) begin
               e = q_exp.pop_front();
               check("pulse_mask", int'(o_out), int'(e.mask));
            end else begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pulse: got out=%b at cycle %0d, required 0", o_out, k);
            end
         end
      end
   end

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr();
      for (int c = 0; c < W; c++) dut_pulses[c] = 0;
      ch0_pulses.delete();
   endtask

   initial begin : driver
      int k0;
      int n_seg;
      clr();
      // reset with all buttons held
      rst = 1'b1;
      i_in = '1;
      run(3);
      check("rst_stable", int'(o_stable), 0);
      check("rst_out", int'(o_out), 0);
      check("rst_toggle", int'(o_toggle), 0);
      rst = 1'b0;
      i_in = '0;
      run(6);
      check("post_rst_pulses", dut_pulses[0] + dut_pulses[1] + dut_pulses[2] + dut_pulses[3], 0);

      // clean press on channel 0
      clr();
      i_in[0] = 1'b1;
      run(40 + int'($urandom_range(0, 3)));
      i_in[0] = 1'b0;
      run(3);
      check("release_stable0", int'(o_stable[0]), 0);
      run(8);
`ifndef BUTTON_REPEAT_EN
      check("press_pulses0", dut_pulses[0], 1);
      check("press_toggle0", int'(o_toggle[0]), 1);
`endif

      // bounce on channel 1
      clr();
      run(int'($urandom_range(0, 3)));
      for (int r = 0; r < 5; r++) begin
         i_in[1] = 1'b1;
         run(3);
         i_in[1] = 1'b0;
         run(3);
      end
      run(6);
      check("bounce_pulses1", dut_pulses[1], 0);
      check("bounce_toggle1", int'(o_toggle[1]), 0);

      // two presses on channel 2, simultaneous press on channel 3
      clr();
      i_in[2] = 1'b1;
      i_in[3] = 1'b1;
      run(40);
      i_in[2] = 1'b0;
      i_in[3] = 1'b0;
      run(20);
      i_in[2] = 1'b1;
      run(40);
      i_in[2] = 1'b0;
      run(10);
`ifndef BUTTON_REPEAT_EN
      check("two_press_pulses2", dut_pulses[2], 2);
      check("two_press_toggle2", int'(o_toggle[2]), 0);
      check("simul_pulses3", dut_pulses[3], 1);
      check("simul_toggle3", int'(o_toggle[3]), 1);
`endif

      // reset in the middle of a press
      clr();
      i_in[0] = 1'b1;
      run(8);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      k0 = k + 1;
      run(30);
      i_in[0] = 1'b0;
      run(8);
      check("midrst_first_pulse_seen", int'(ch0_pulses.size() > 0), 1);
      if (ch0_pulses.size() > 0)
         check_range("requal_latency", ch0_pulses[0] - (k0 + 1), (P - 1) * M + 1, P * M + 1);
`ifndef BUTTON_REPEAT_EN
      check("midrst_pulses0", dut_pulses[0], 1);
`endif

      // long hold on channel 0: repeat spacing or single pulse
      clr();
      i_in[0] = 1'b1;
      run(60);
      i_in[0] = 1'b0;
      run(8);
`ifdef BUTTON_REPEAT_EN
      check("repeat_count_min", int'(ch0_pulses.size() >= 7), 1);
      for (int i = 1; i < ch0_pulses.size(); i++)
         check("repeat_interval", ch0_pulses[i] - ch0_pulses[i-1], R * M);
`else
      check("hold_single_pulse", ch0_pulses.size(), 1);
`endif

      // random segments with occasional resets
      clr();
      n_seg = 30;
      for (int s = 0; s < n_seg; s++) begin
         i_in = W'($urandom);
         rst = ($urandom_range(0, 15) == 0);
         run(1);
         rst = 1'b0;
         run(int'($urandom_range(1, 24)));
      end
      i_in = '0;
      run(20);

      check("queue_empty", q_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
